// File: rtl/avalon_vga_rect_fill.sv
// Rectangle fill engine: CSR slave programs a rectangle and colour, the master
// streams one frame-buffer write per pixel, then an optional buffer-swap write.
module avalon_vga_rect_fill #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_reset_n,
    input  logic [2:0]  i_s_address,
    input  logic        i_s_chipselect,
    input  logic        i_s_read,
    input  logic        i_s_write,
    input  logic [31:0] i_s_writedata,
    output logic [31:0] o_s_readdata,
    output logic        o_s_readdatavalid,
    output logic [19:0] o_m_address,
    output logic        o_m_write,
    output logic [31:0] o_m_writedata,
    input  logic        i_m_waitrequest,
    output logic        o_irq
);
    localparam logic [9:0]  X_MAX     = 10'(H_RES - 1);
    localparam logic [9:0]  Y_MAX     = 10'(V_RES - 1);
    localparam logic [18:0] H_STEP    = 19'(H_RES);
    localparam logic [19:0] SWAP_ADDR = 20'h80000;

    typedef enum logic [1:0] {IDLE, FILL, SWAP, FINISH} state_t;
    state_t state, state_nxt;

    logic [9:0]  x0, y0, x1, y1, cur_x, cur_y, ex1, ey1, ex1_c, ey1_c;
    logic [2:0]  color;
    logic        busy, done, swap_en, abort_pend;
    logic [18:0] count, row_base;
    logic [19:0] m_addr;
    logic [31:0] m_data, rd_mux;
    logic        m_write;
    logic        csr_wr, csr_rd, ctrl_wr, start_req, abort_req, eff_abort;
    logic        accept, last_pix, empty_c;
    logic        unused_wd;

    // Start-of-fill row base y*H_RES as a constant shift-add sum.
    function automatic logic [18:0] row_of(input logic [9:0] y);
        logic [18:0] acc;
        acc = '0;
        for (int i = 0; i < 19; i++)
            if (H_STEP[i]) acc = acc + (19'(y) << i);
        return acc;
    endfunction

    assign unused_wd  = ^i_s_writedata[31:10];
    assign csr_wr     = i_s_chipselect & i_s_write;
    assign csr_rd     = i_s_chipselect & i_s_read;
    assign ctrl_wr    = csr_wr && (i_s_address == 3'd5);
    assign start_req  = ctrl_wr && i_s_writedata[0] && !i_s_writedata[2] && !busy && (state == IDLE);
    assign abort_req  = ctrl_wr && i_s_writedata[2] && busy;
    assign eff_abort  = abort_req | abort_pend;
    assign accept     = m_write & ~i_m_waitrequest;
    assign last_pix   = (cur_x == ex1) && (cur_y == ey1);
    assign ex1_c      = (x1 > X_MAX) ? X_MAX : x1;
    assign ey1_c      = (y1 > Y_MAX) ? Y_MAX : y1;
    assign empty_c    = (x0 > ex1_c) || (y0 > ey1_c);

    assign o_m_address       = m_addr;
    assign o_m_write         = m_write;
    assign o_m_writedata     = m_data;
    assign o_irq             = done;

    always_comb begin
        rd_mux = '0;
        case (i_s_address)
            3'd0: rd_mux = {22'b0, x0};
            3'd1: rd_mux = {22'b0, y0};
            3'd2: rd_mux = {22'b0, x1};
            3'd3: rd_mux = {22'b0, y1};
            3'd4: rd_mux = {29'b0, color};
            3'd6: rd_mux = {30'b0, done, busy};
            3'd7: rd_mux = {13'b0, count};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_cpu_clk or negedge i_cpu_reset_n) begin
        if (!i_cpu_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (start_req) begin
                    if (!empty_c)              state_nxt = FILL;
                    else if (i_s_writedata[1]) state_nxt = SWAP;
                    else                       state_nxt = FINISH;
                end
            FILL:
                if (accept) begin
                    if (eff_abort)     state_nxt = FINISH;
                    else if (last_pix) state_nxt = swap_en ? SWAP : FINISH;
                end
            SWAP:    if (accept) state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk or negedge i_cpu_reset_n) begin
        if (!i_cpu_reset_n) begin
            x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0; color <= '0;
            busy <= 1'b0; done <= 1'b0; swap_en <= 1'b0; abort_pend <= 1'b0;
            count <= '0; row_base <= '0; cur_x <= '0; cur_y <= '0;
            ex1 <= '0; ey1 <= '0;
            m_addr <= '0; m_data <= '0; m_write <= 1'b0;
            o_s_readdata <= '0; o_s_readdatavalid <= 1'b0;
        end else begin
            o_s_readdatavalid <= csr_rd;
            o_s_readdata      <= csr_rd ? rd_mux : '0;

            if (csr_wr && !busy) begin
                case (i_s_address)
                    3'd0: x0    <= i_s_writedata[9:0];
                    3'd1: y0    <= i_s_writedata[9:0];
                    3'd2: x1    <= i_s_writedata[9:0];
                    3'd3: y1    <= i_s_writedata[9:0];
                    3'd4: color <= i_s_writedata[2:0];
                    default: ;
                endcase
            end

            // An abort seen while a write is stalled is remembered until it lands.
            abort_pend <= ((state == FILL) || (state == SWAP)) && (state_nxt == state) && eff_abort;

            if (state == FINISH) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else if (start_req) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (csr_wr && (i_s_address == 3'd6) && i_s_writedata[1]) begin
                done <= 1'b0;
            end

            case (state)
                IDLE:
                    if (start_req) begin
                        ex1      <= ex1_c;
                        ey1      <= ey1_c;
                        swap_en  <= i_s_writedata[1];
                        cur_x    <= x0;
                        cur_y    <= y0;
                        row_base <= row_of(y0);
                        count    <= '0;
                        if (!empty_c) begin
                            m_addr  <= {1'b0, row_of(y0) + 19'(x0)};
                            m_data  <= {29'b0, color};
                            m_write <= 1'b1;
                        end else if (i_s_writedata[1]) begin
                            m_addr  <= SWAP_ADDR;
                            m_data  <= '0;
                            m_write <= 1'b1;
                        end else begin
                            m_write <= 1'b0;
                        end
                    end
                FILL:
                    if (accept) begin
                        count <= count + 19'd1;
                        if (eff_abort) begin
                            m_write <= 1'b0;
                        end else if (last_pix) begin
                            if (swap_en) begin
                                m_addr <= SWAP_ADDR;
                                m_data <= '0;
                            end else begin
                                m_write <= 1'b0;
                            end
                        end else if (cur_x == ex1) begin
                            cur_x    <= x0;
                            cur_y    <= cur_y + 10'd1;
                            row_base <= row_base + H_STEP;
                            m_addr   <= {1'b0, row_base + H_STEP + 19'(x0)};
                        end else begin
                            cur_x  <= cur_x + 10'd1;
                            m_addr <= m_addr + 20'd1;
                        end
                    end
                SWAP:    if (accept) m_write <= 1'b0;
                default: m_write <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_vga_rect_fill.sv
// Directed bench for the rectangle fill engine; a negedge monitor scores master
// writes and CSR read data against queues filled by the stimulus.
module tb_avalon_vga_rect_fill;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  s_addr = '0;
    logic        cs = 1'b0, rd_s = 1'b0, wr_s = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rdata;
    logic        rdv;
    logic [19:0] m_addr;
    logic        m_write;
    logic [31:0] m_wdata;
    logic        waitreq = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    avalon_vga_rect_fill #(.H_RES(640), .V_RES(480)) dut (
        .i_cpu_clk(clk), .i_cpu_reset_n(rst_n),
        .i_s_address(s_addr), .i_s_chipselect(cs), .i_s_read(rd_s), .i_s_write(wr_s),
        .i_s_writedata(wd), .o_s_readdata(rdata), .o_s_readdatavalid(rdv),
        .o_m_address(m_addr), .o_m_write(m_write), .o_m_writedata(m_wdata),
        .i_m_waitrequest(waitreq), .o_irq(irq)
    );

    int n_checks = 0, n_fail = 0;
    int cyc = 0, acc_cnt = 0, hold1_cnt = 0;
    int stall_at = -1, stall_len = 0, stall_done = 0;
    logic [51:0] wq[$];
    logic [31:0] rq[$];
    string       rnq[$];
    int          acc_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Slave model: stalls the write presented when acc_cnt == stall_at.
    always @(posedge clk) begin
        #1;
        if (m_write && acc_cnt == stall_at && stall_done < stall_len) begin
            waitreq = 1'b1;
            stall_done++;
        end else begin
            waitreq = 1'b0;
        end
    end

    always @(negedge clk) begin : mon
        logic [51:0] e;
        logic        prev_stall;
        logic [19:0] prev_addr;
        logic [31:0] prev_data;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (m_write && m_addr == 20'd1) hold1_cnt++;
            if (prev_stall) begin
                check("hold_write", {31'b0, m_write}, 32'd1);
                check("hold_addr", {12'b0, m_addr}, {12'b0, prev_addr});
                check("hold_data", m_wdata, prev_data);
            end
            prev_stall = m_write && waitreq;
            prev_addr  = m_addr;
            prev_data  = m_wdata;
            if (m_write && !waitreq) begin
                acc_cnt++;
                acc_cyc.push_back(cyc);
                if (wq.size() == 0) begin
                    check("unexpected_write", {12'b0, m_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = wq.pop_front();
                    check("write_addr", {12'b0, m_addr}, {12'b0, e[51:32]});
                    check("write_data", m_wdata, e[31:0]);
                end
            end
            if (rdv) begin
                if (rq.size() == 0) check("unexpected_rdv", rdata, 32'hFFFF_FFFF);
                else check(rnq.pop_front(), rdata, rq.pop_front());
            end
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; wr_s = 1'b1; s_addr = a; wd = d;
        @(posedge clk); #1;
        cs = 1'b0; wr_s = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        rq.push_back(exp);
        rnq.push_back(nm);
        @(posedge clk); #1;
        cs = 1'b1; rd_s = 1'b1; s_addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd_s = 1'b0;
    endtask

    task automatic push_w(input logic [19:0] a, input logic [31:0] d);
        wq.push_back({a, d});
    endtask

    task automatic set_rect(input int xa, input int ya, input int xb, input int yb, input logic [31:0] c);
        csr_wr(3'd0, 32'(xa)); csr_wr(3'd1, 32'(ya));
        csr_wr(3'd2, 32'(xb)); csr_wr(3'd3, 32'(yb));
        csr_wr(3'd4, c);
        csr_wr(3'd6, 32'h2);
    endtask

    task automatic new_test(input int s_at, input int s_len);
        acc_cnt = 0; acc_cyc.delete(); hold1_cnt = 0;
        stall_at = s_at; stall_len = s_len; stall_done = 0;
    endtask

    task automatic wait_irq(input string nm, input int lim);
        int c = 0;
        while (!irq && c < lim) begin
            @(posedge clk); #1;
            c++;
        end
        check(nm, {31'b0, irq}, 32'd1);
    endtask

    initial begin
        #12;
        check("rst_m_write", {31'b0, m_write}, 32'd0);
        check("rst_m_addr", {12'b0, m_addr}, 32'd0);
        check("rst_m_data", m_wdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_rdv", {31'b0, rdv}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        csr_rd(3'd6, 32'd0, "rst_status");
        csr_rd(3'd7, 32'd0, "rst_count");
        csr_rd(3'd0, 32'd0, "rst_x0");

        // Basic 4x2 rect, no stalls, upper colour bits must be dropped.
        new_test(-1, 0);
        set_rect(0, 0, 3, 1, 32'hFFFF_FFF5);
        csr_rd(3'd4, 32'd5, "color_mask");
        csr_rd(3'd2, 32'd3, "x1_readback");
        for (int i = 0; i < 4; i++) push_w(20'(i), 32'd5);
        for (int i = 0; i < 4; i++) push_w(20'(640 + i), 32'd5);
        csr_wr(3'd5, 32'h1);
        wait_irq("basic_irq", 200);
        check("basic_writes", wq.size(), 0);
        check("basic_n_acc", acc_cnt, 8);
        if (acc_cyc.size() == 8) check("basic_no_bubble", acc_cyc[7] - acc_cyc[0], 7);
        csr_rd(3'd7, 32'd8, "basic_count");
        csr_rd(3'd6, 32'd2, "basic_status");
        csr_wr(3'd6, 32'h2);
        @(negedge clk);
        check("irq_clear", {31'b0, irq}, 32'd0);

        // Same rect, second write stalled three cycles.
        new_test(1, 3);
        for (int i = 0; i < 4; i++) push_w(20'(i), 32'd5);
        for (int i = 0; i < 4; i++) push_w(20'(640 + i), 32'd5);
        csr_wr(3'd5, 32'h1);
        wait_irq("stall_irq", 200);
        check("stall_writes", wq.size(), 0);
        check("stall_hold_cycles", hold1_cnt, 4);
        csr_rd(3'd7, 32'd8, "stall_count");

        // Bottom-right corner with clipped X1 and swap.
        new_test(-1, 0);
        set_rect(638, 479, 1000, 479, 32'd2);
        csr_rd(3'd2, 32'd1000, "x1_raw");
        push_w(20'd307198, 32'd2);
        push_w(20'd307199, 32'd2);
        push_w(20'h80000, 32'd0);
        csr_wr(3'd5, 32'h3);
        wait_irq("swap_irq", 200);
        check("swap_writes", wq.size(), 0);
        csr_rd(3'd7, 32'd2, "swap_count");

        // Empty rect: no pixels, DONE two cycles after START.
        new_test(-1, 0);
        set_rect(5, 0, 4, 0, 32'd1);
        csr_wr(3'd5, 32'h1);
        @(posedge clk); #1;
        check("empty_done_2cyc", {31'b0, irq}, 32'd1);
        csr_rd(3'd7, 32'd0, "empty_count");
        check("empty_n_acc", acc_cnt, 0);

        // Full screen, ABORT while the 101st write is stalled.
        new_test(100, 10);
        set_rect(0, 0, 639, 479, 32'd7);
        for (int i = 0; i < 101; i++) push_w(20'(i), 32'd7);
        csr_wr(3'd5, 32'h3);
        csr_wr(3'd0, 32'd9);
        csr_wr(3'd5, 32'h1);
        begin
            int c = 0;
            while (!(acc_cnt == 100 && waitreq) && c < 2000) begin
                @(posedge clk); #2;
                c++;
            end
            check("abort_window", {31'b0, (acc_cnt == 100 && waitreq)}, 32'd1);
        end
        csr_wr(3'd5, 32'h4);
        wait_irq("abort_irq", 200);
        repeat (5) @(posedge clk);
        #1;
        check("abort_writes", wq.size(), 0);
        check("abort_n_acc", acc_cnt, 101);
        csr_rd(3'd7, 32'd101, "abort_count");
        csr_rd(3'd6, 32'd2, "abort_status");
        csr_rd(3'd0, 32'd0, "busy_x0_ignored");

        // START together with ABORT while idle: nothing starts.
        new_test(-1, 0);
        csr_wr(3'd6, 32'h2);
        csr_wr(3'd5, 32'h5);
        repeat (3) @(posedge clk);
        csr_rd(3'd6, 32'd0, "start_abort_status");
        check("start_abort_n_acc", acc_cnt, 0);

        // Reset in the middle of a fill.
        new_test(-1, 0);
        set_rect(0, 0, 639, 479, 32'd3);
        for (int i = 0; i < 200; i++) push_w(20'(i), 32'd3);
        csr_wr(3'd5, 32'h1);
        begin
            int c = 0;
            while (acc_cnt < 20 && c < 500) begin
                @(posedge clk); #1;
                c++;
            end
        end
        @(negedge clk);
        check("pre_rst_write", {31'b0, m_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_write", {31'b0, m_write}, 32'd0);
        check("midrst_m_addr", {12'b0, m_addr}, 32'd0);
        check("midrst_m_data", m_wdata, 32'd0);
        wq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        acc_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        check("no_resume", acc_cnt, 0);
        csr_rd(3'd6, 32'd0, "post_rst_status");
        csr_rd(3'd7, 32'd0, "post_rst_count");
        csr_wr(3'd0, 32'd3);
        csr_rd(3'd0, 32'd3, "post_rst_x0");
        repeat (2) @(posedge clk);
        #1;
        check("reads_drained", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/avalon_vga_rect_fill.md
AVALON_VGA_RECT_FILL -- requirements
Module: avalon_vga_rect_fill

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines per frame
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_cpu_clk, in, 1, sole clock
- i_cpu_reset_n, in, 1, asynchronous active-low reset
- i_s_address, in, 3, CSR word select
- i_s_chipselect, in, 1, CSR select
- i_s_read, in, 1, CSR read strobe
- i_s_write, in, 1, CSR write strobe
- i_s_writedata, in, 32, CSR write data
- o_s_readdata, out, 32, CSR read data
- o_s_readdatavalid, out, 1, CSR read data valid
- o_m_address, out, 20, master address to the VGA frame-buffer slave
- o_m_write, out, 1, master write request
- o_m_writedata, out, 32, master write data
- i_m_waitrequest, in, 1, master stall from the slave
- o_irq, out, 1, level interrupt, fill complete
REQ-003 One clock, i_cpu_clk; reset i_cpu_reset_n is asynchronous, active-low.

Function
REQ-004 CSR map (word index): 0 X0[9:0], 1 Y0[9:0], 2 X1[9:0], 3 Y1[9:0], 4 COLOR[2:0], 5 CTRL (write only: bit0 START, bit1 SWAP_EN, bit2 ABORT), 6 STATUS (read: bit0 BUSY, bit1 DONE), 7 COUNT[18:0] (pixels written, read only).
REQ-005 CSR reads SHALL have fixed latency 1: o_s_readdatavalid asserts the cycle after chipselect&read; o_s_readdata is zero-extended; unused bits read 0.
REQ-006 While BUSY, writes to indices 0-4 SHALL be ignored, and START SHALL be ignored.
REQ-007 A write to STATUS with bit1=1 SHALL clear DONE and deassert o_irq; o_irq = DONE.
REQ-008 FSM states SHALL be IDLE, FILL, SWAP, FINISH.
REQ-009 IDLE->FILL on START; the engine latches the effective rectangle as ex1=min(X1,H_RES-1) and ey1=min(Y1,V_RES-1); it clears COUNT and DONE and sets BUSY.
REQ-010 If X0>ex1 or Y0>ey1, the rectangle is empty; IDLE SHALL go directly to SWAP (if SWAP_EN) or FINISH, and zero pixels are written.
REQ-011 FILL SHALL issue one write per pixel in raster order, from (X0,Y0) to (ex1,ey1): x increments first, then y.
REQ-012 Pixel address fields:
- o_m_address[19] = 0
- o_m_address[18:0] = y*H_RES + x, formed incrementally with a row base plus H_RES per row; no multiplier
- o_m_writedata = {29'b0, COLOR}
REQ-013 While o_m_write=1 and i_m_waitrequest=1, o_m_address, o_m_writedata and o_m_write SHALL hold stable; a transfer completes on a cycle with o_m_write=1 and i_m_waitrequest=0.
REQ-014 With waitrequest low, one pixel SHALL complete per clock, with no bubbles across row boundaries.
REQ-015 COUNT SHALL increment by 1 on each completed pixel transfer.
REQ-016 After the last pixel completes, FILL SHALL go to SWAP if SWAP_EN was set at START, otherwise to FINISH.
REQ-017 SWAP SHALL issue one write with o_m_address = 20'h80000 and writedata 0, held until accepted, then go to FINISH.
REQ-018 FINISH SHALL last one cycle: it clears BUSY, sets DONE, then returns to IDLE.
REQ-019 ABORT while BUSY:
- an in-flight transfer (o_m_write=1) SHALL be held until accepted, then go to FINISH with no SWAP
- with no transfer in flight, go to FINISH next cycle
- ABORT in IDLE is ignored
REQ-020 START and ABORT written in the same word: ABORT SHALL take priority; no fill starts.
REQ-021 o_m_write SHALL be 0 in IDLE and FINISH.

Reset
REQ-022 Assertion of i_cpu_reset_n low, at any time including mid-transfer, SHALL immediately force all of the following; no pending write resumes after release:
- o_m_write=0, o_m_address=0, o_m_writedata=0
- o_s_readdatavalid=0, o_s_readdata=0, o_irq=0
- FSM to IDLE
- all CSRs, COUNT, BUSY and DONE to 0

Verification
REQ-023 Rect (0,0)-(3,1), COLOR 5, waitrequest 0 -> 8 consecutive writes at addresses 0,1,2,3,640,641,642,643, data 5; COUNT=8; DONE=1, o_irq=1.
REQ-024 Same rect, waitrequest high 3 cycles on the 2nd write -> address 1 held 4 cycles; total 8 writes; no duplicates.
REQ-025 X1=1000, Y1=479, X0=638, Y0=479, SWAP_EN=1 -> writes at 307198 and 307199, then one write to 0x80000; COUNT=2.
REQ-026 X0=5, X1=4 -> zero pixel writes; DONE=1 within 2 cycles of START; COUNT=0.
REQ-027 Full-screen fill, ABORT after 100 pixels, with waitrequest high at that moment -> the held write completes, then no further writes; COUNT=101; no swap.
REQ-028 Reset pulse during FILL with o_m_write=1 -> o_m_write=0 at once; STATUS reads 0; CSR writes to 0-4 accepted afterwards.
